updown_monitor: RTL and testbench

UPDOWN_MONITOR -- requirements
Module: updown_monitor

---
 rtl/updown_monitor.sv | 160 ++++++++++++++++
 tb/tb_updown_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/updown_monitor.sv
// updown_monitor: watches a 4-bit up/down counter and checks each new sample
// against the previous sample stepped in the previously driven direction.
// It acquires lock after LOCK_N consecutive good steps, flags each broken
// step while locked or faulted, counts those errors with saturation, and
// pulses Wrap on every correctly observed 15->0 or 0->15 step.
module updown_monitor #(
    parameter int LOCK_N = 3,   // consecutive matches needed to lock (1..7)
    parameter int CNT_W  = 8    // width of the saturating error counter
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             Down,
    input  logic [3:0]       Q,
    output logic             Locked,
    output logic             Fault,
    output logic             Err,
    output logic [CNT_W-1:0] Err_cnt,
    output logic             Wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [2:0] LOCK_N_C = 3'(LOCK_N);

    // Value the counter must show next, given last sample and last direction.
    function automatic logic [3:0] exp_next(input logic [3:0] q, input logic dn);
        return dn ? (q - 4'd1) : (q + 4'd1);
    endfunction

    // True when the step from q in direction dn crosses the 4-bit boundary.
    function automatic logic is_wrap(input logic [3:0] q, input logic dn);
        return (!dn && (q == 4'hF)) || (dn && (q == 4'h0));
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : (c + CNT_W'(1));
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_match_cnt;
    logic [2:0]  w_match_cnt_nxt;
    logic [2:0]  w_match_inc;
    logic [3:0]  r_q_prev;
    logic        r_down_prev;
    logic [3:0]  w_exp;
    logic        w_match;
    logic        w_wrap_step;
    logic        w_err_nxt;
    logic        w_wrap_nxt;

    assign w_exp       = exp_next(r_q_prev, r_down_prev);
    assign w_match     = (Q == w_exp);
    assign w_wrap_step = is_wrap(r_q_prev, r_down_prev);
    assign w_match_inc = r_match_cnt + 3'd1;

    // Sample history: the previous value and direction define the next expectation.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_q_prev    <= 4'd0;
            r_down_prev <= 1'b0;
        end else begin
            r_q_prev    <= Q;
            r_down_prev <= Down;
        end
    end

    // State and match-run counter registers.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_match_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_cnt_nxt;
        end
    end

    // Next-state decode; Err and Wrap are decided from the current sample here.
    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_err_nxt       = 1'b0;
        w_wrap_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                // First edge only captures history; nothing to compare yet.
                w_state_nxt     = SYNC;
                w_match_cnt_nxt = 3'd0;
            end
            SYNC: begin
                if (w_match) begin
                    w_wrap_nxt = w_wrap_step;
                    if (w_match_inc == LOCK_N_C) begin
                        w_state_nxt     = LOCKED;
                        w_match_cnt_nxt = 3'd0;
                    end else begin
                        w_match_cnt_nxt = w_match_inc;
                    end
                end else begin
                    // Still acquiring: a bad step just restarts the run silently.
                    w_match_cnt_nxt = 3'd0;
                end
            end
            LOCKED: begin
                if (w_match) begin
                    w_wrap_nxt = w_wrap_step;
                end else begin
                    w_err_nxt       = 1'b1;
                    w_match_cnt_nxt = 3'd0;
                    w_state_nxt     = FAULT;
                end
            end
            FAULT: begin
                if (w_match) begin
                    w_wrap_nxt = w_wrap_step;
                    if (w_match_inc == LOCK_N_C) begin
                        w_state_nxt     = LOCKED;
                        w_match_cnt_nxt = 3'd0;
                    end else begin
                        w_match_cnt_nxt = w_match_inc;
                    end
                end else begin
                    w_err_nxt       = 1'b1;
                    w_match_cnt_nxt = 3'd0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_match_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Registered outputs: status follows the next state so it is valid the cycle after the deciding edge.
    always_ff @(posedge clock) begin
        if (Reset) begin
            Locked  <= 1'b0;
            Fault   <= 1'b0;
            Err     <= 1'b0;
            Wrap    <= 1'b0;
            Err_cnt <= '0;
        end else begin
            Locked <= (w_state_nxt == LOCKED);
            Fault  <= (w_state_nxt == FAULT);
            Err    <= w_err_nxt;
            Wrap   <= w_wrap_nxt;
            if (w_err_nxt) begin
                Err_cnt <= sat_inc(Err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_updown_monitor.sv
// Bench for updown_monitor: a behavioural model predicts the registered
// outputs for every driven sample, queues them, and a monitor compares them
// one cycle later against the DUT.
module tb_updown_monitor;

    localparam int LOCK_N = 3;
    localparam int CNT_W  = 8;

    logic             clock;
    logic             Reset;
    logic             Down;
    logic [3:0]       Q;
    logic             Locked;
    logic             Fault;
    logic             Err;
    logic [CNT_W-1:0] Err_cnt;
    logic             Wrap;

    typedef struct {
        logic        locked;
        logic        fault;
        logic        err;
        logic        wrap;
        logic [31:0] ecnt;
        int          idx;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_samples = 0;

    // Model state: 0 idle, 1 sync, 2 locked, 3 fault
    int m_state = 0;
    int m_cnt   = 0;
    int m_q     = 0;
    int m_d     = 0;
    int m_ec    = 0;

    updown_monitor #(.LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .Reset   (Reset),
        .Down    (Down),
        .Q       (Q),
        .Locked  (Locked),
        .Fault   (Fault),
        .Err     (Err),
        .Err_cnt (Err_cnt),
        .Wrap    (Wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Drive one sample on the falling edge and queue the model's prediction.
    task automatic drive(input int rst, input int q, input int dn);
        exp_t e;
        int   ex;
        int   match;
        @(negedge clock);
        Reset = rst[0];
        Q     = q[3:0];
        Down  = dn[0];
        e.err  = 1'b0;
        e.wrap = 1'b0;
        if (rst != 0) begin
            m_state = 0; m_cnt = 0; m_q = 0; m_d = 0; m_ec = 0;
        end else begin
            ex    = (m_d != 0) ? (m_q + 15) % 16 : (m_q + 1) % 16;
            match = (q == ex);
            case (m_state)
                0: begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (match) begin
                        e.wrap = ((m_q == 15 && m_d == 0) || (m_q == 0 && m_d == 1));
                        m_cnt++;
                        if (m_cnt == LOCK_N) begin m_state = 2; m_cnt = 0; end
                    end else m_cnt = 0;
                end
                2: begin
                    if (match) e.wrap = ((m_q == 15 && m_d == 0) || (m_q == 0 && m_d == 1));
                    else begin e.err = 1'b1; m_state = 3; m_cnt = 0; end
                end
                default: begin
                    if (match) begin
                        e.wrap = ((m_q == 15 && m_d == 0) || (m_q == 0 && m_d == 1));
                        m_cnt++;
                        if (m_cnt == LOCK_N) begin m_state = 2; m_cnt = 0; end
                    end else begin e.err = 1'b1; m_cnt = 0; end
                end
            endcase
            if (e.err && m_ec < 255) m_ec++;
            m_q = q;
            m_d = dn;
        end
        e.locked = (m_state == 2);
        e.fault  = (m_state == 3);
        e.ecnt   = m_ec;
        e.idx    = n_samples;
        n_samples++;
        sb.push_back(e);
    endtask

    // Monitor: compare DUT outputs one time unit after each rising edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val($sformatf("locked[%0d]", e.idx), Locked, e.locked);
            check_val($sformatf("fault[%0d]", e.idx), Fault, e.fault);
            check_val($sformatf("err[%0d]", e.idx), Err, e.err);
            check_val($sformatf("wrap[%0d]", e.idx), Wrap, e.wrap);
            check_val($sformatf("err_cnt[%0d]", e.idx), Err_cnt, e.ecnt);
            check_val($sformatf("err_and_wrap[%0d]", e.idx), Err & Wrap, 0);
            check_val($sformatf("locked_and_fault[%0d]", e.idx), Locked & Fault, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        Down  = 1'b0;
        Q     = 4'd0;

        // Reset two cycles, then count up to lock, across 15->0, on to 5
        drive(1, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 22; i++) drive(0, i % 16, 0);

        // Direction flip at 5: 6 sampled with Down=1, then down through 0->15
        drive(0, 6, 1);
        for (int i = 0; i < 8; i++) drive(0, (5 - i + 16) % 16, 1);

        // Back to up, then wrap combined with direction changes
        drive(0, 13, 0);
        drive(0, 14, 0);
        drive(0, 15, 0);
        drive(0, 0, 1);
        drive(0, 15, 1);
        drive(0, 14, 0);
        drive(0, 15, 0);
        for (int i = 0; i < 8; i++) drive(0, i, 0);

        // Skip 7->9 while locked, recover with three good steps
        drive(0, 9, 0);
        for (int i = 10; i < 13; i++) drive(0, i, 0);

        // Stall three cycles to reach FAULT with Err_cnt=4, then reset once
        for (int i = 0; i < 3; i++) drive(0, 12, 0);
        drive(1, 12, 0);
        for (int i = 0; i < 4; i++) drive(0, i, 0);

        // Hold Q constant long enough to saturate the error counter
        for (int i = 0; i < 300; i++) drive(0, 3, 0);

        // Reset, mismatch during SYNC, lock, partial recovery broken by a mismatch
        drive(1, 0, 0);
        drive(0, 5, 0);
        drive(0, 6, 0);
        drive(0, 9, 0);
        for (int i = 10; i < 14; i++) drive(0, i, 0);
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 5, 0);
        for (int i = 6; i < 10; i++) drive(0, i, 0);

        // Let the monitor consume the remaining predictions
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        check_val("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
